// File: rtl/crop_downsample_frame.sv
// Crops a raster pixel stream to an NX x NY sample grid, either by point sampling
// or by 2^AVG_LOG2 box averaging, and captures exactly one frame per arm request.
module crop_downsample_frame #(
  parameter int IN_W     = 12,
  parameter int OUT_W    = 8,
  parameter int XW       = 10,
  parameter int X0       = 27,
  parameter int Y0       = 17,
  parameter int SX       = 21,
  parameter int SY       = 16,
  parameter int NX       = 28,
  parameter int NY       = 28,
  parameter int AVG_LOG2 = 1
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iDVAL,
  input  logic [XW-1:0]                iX,
  input  logic [XW-1:0]                iY,
  input  logic [IN_W-1:0]              iGray,
  input  logic                         iArm,
  input  logic                         iMode,
  input  logic                         iAbort,
  output logic [OUT_W-1:0]             oPxl,
  output logic                         oDVAL,
  output logic [$clog2(NX*NY)-1:0]     oIdx,
  output logic                         oDone,
  output logic                         oBusy
);

  localparam int unsigned IW   = $clog2(NX*NY);
  localparam int unsigned CW   = (NX > 1) ? $clog2(NX) : 1;
  localparam int unsigned RW   = (NY > 1) ? $clog2(NY) : 1;
  localparam int unsigned AW   = IN_W + 2*AVG_LOG2;
  localparam int unsigned BOX  = 1 << AVG_LOG2;
  localparam int unsigned LAST = NX*NY - 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SOF, S_CAPTURE, S_DONE} state_t;

  state_t            r_state, w_next;
  logic              r_mode;
  logic [AW-1:0]     r_acc [NX];
  logic              r_oDVAL;
  logic [OUT_W-1:0]  r_oPxl;
  logic [IW-1:0]     r_oIdx;

  logic              w_xin, w_xlo, w_xhi, w_yin, w_ylo, w_yhi;
  logic [CW-1:0]     w_c;
  logic [RW-1:0]     w_r;
  logic              w_sof, w_start, w_restart, w_proc, w_in_blk, w_emit, w_clear_all;
  logic [IW-1:0]     w_idx;
  logic [AW-1:0]     w_acc_base, w_sum;
  logic [OUT_W-1:0]  w_box_pxl, w_pt_pxl;

  // Constant-bound window comparators replace any run-time division by the stride.
  always_comb begin
    w_xin = 1'b0; w_xlo = 1'b0; w_xhi = 1'b0; w_c = '0;
    for (int unsigned c = 0; c < NX; c++) begin
      if (iX >= XW'(X0 + c*SX) && iX <= XW'(X0 + c*SX + BOX - 1)) begin
        w_xin = 1'b1;
        w_c   = CW'(c);
        w_xlo = (iX == XW'(X0 + c*SX));
        w_xhi = (iX == XW'(X0 + c*SX + BOX - 1));
      end
    end
  end

  always_comb begin
    w_yin = 1'b0; w_ylo = 1'b0; w_yhi = 1'b0; w_r = '0;
    for (int unsigned r = 0; r < NY; r++) begin
      if (iY >= XW'(Y0 + r*SY) && iY <= XW'(Y0 + r*SY + BOX - 1)) begin
        w_yin = 1'b1;
        w_r   = RW'(r);
        w_ylo = (iY == XW'(Y0 + r*SY));
        w_yhi = (iY == XW'(Y0 + r*SY + BOX - 1));
      end
    end
  end

  assign w_sof       = (iX == '0) && (iY == '0);
  assign w_start     = (r_state == S_WAIT_SOF) && iDVAL && w_sof && !iAbort;
  assign w_restart   = (r_state == S_CAPTURE)  && iDVAL && w_sof && !iAbort;
  assign w_proc      = iDVAL && !iAbort && ((r_state == S_CAPTURE) || w_start);
  assign w_in_blk    = w_proc && w_xin && w_yin;
  assign w_emit      = r_mode ? (w_in_blk && w_xhi && w_yhi) : (w_in_blk && w_xlo && w_ylo);
  assign w_clear_all = w_start || w_restart ||
                       (iAbort && ((r_state == S_WAIT_SOF) || (r_state == S_CAPTURE)));
  assign w_idx       = IW'(32'(w_r) * 32'(NX) + 32'(w_c));

  // A frame (re)start pixel sees a cleared accumulator even before the clear lands.
  assign w_acc_base  = (w_start || w_restart) ? '0 : r_acc[w_c];
  assign w_sum       = w_acc_base + AW'(iGray);
  assign w_box_pxl   = OUT_W'(w_sum >> (2*AVG_LOG2 + IN_W - OUT_W));
  assign w_pt_pxl    = OUT_W'(iGray >> (IN_W - OUT_W));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (iArm) w_next = S_WAIT_SOF;
      S_WAIT_SOF: if (iAbort) w_next = S_IDLE;
                  else if (w_start) w_next = S_CAPTURE;
      S_CAPTURE:  if (iAbort) w_next = S_IDLE;
                  else if (r_oDVAL && r_oIdx == IW'(LAST)) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && iArm) r_mode <= iMode;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int unsigned c = 0; c < NX; c++) r_acc[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NX; c++) begin
        if (r_mode && w_in_blk && w_c == CW'(c)) r_acc[c] <= w_emit ? '0 : w_sum;
        else if (w_clear_all)                    r_acc[c] <= '0;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_oDVAL <= 1'b0;
      r_oPxl  <= '0;
      r_oIdx  <= '0;
    end else begin
      r_oDVAL <= w_emit;
      if (w_emit) begin
        r_oPxl <= r_mode ? w_box_pxl : w_pt_pxl;
        r_oIdx <= w_idx;
      end else if (r_state == S_IDLE) begin
        r_oIdx <= '0;
      end
    end
  end

  assign oDVAL = r_oDVAL;
  assign oPxl  = r_oPxl;
  assign oIdx  = r_oIdx;
  assign oDone = (r_state == S_DONE);
  assign oBusy = (r_state == S_WAIT_SOF) || (r_state == S_CAPTURE);

endmodule

// File: doc/crop_downsample_frame.md
Name: crop_downsample_frame

Overview:
- Parametrised successor to the fixed 28x28 crop/sample stage in the image-processing path.
- Sits between the grayscale converter and the normaliser/NN input buffer.
- Takes the raster camera pixel stream with coordinates, crops a window, and decimates it to an NX x NY image.
- Two runtime modes: point sampling or power-of-two box averaging. Captures exactly one frame per arm request, with pixel index and frame-done outputs.

Parameters:
- IN_W, 12, input gray pixel width
- OUT_W, 8, output pixel width (OUT_W <= IN_W)
- XW, 10, coordinate width
- X0, 27, first sampled column
- Y0, 17, first sampled row
- SX, 21, column stride
- SY, 16, row stride
- NX, 28, output columns
- NY, 28, output rows
- AVG_LOG2, 1, box size is 2^AVG_LOG2 square; requires 2^AVG_LOG2 <= SX and 2^AVG_LOG2 <= SY

Ports:
- iCLK  in  1  clock
- iRST  in  1  asynchronous active-low reset
- iDVAL  in  1  input pixel valid
- iX  in  XW  input column
- iY  in  XW  input row
- iGray  in  IN_W  gray pixel
- iArm  in  1  pulse: capture next frame
- iMode  in  1  0 = point sample, 1 = box average; latched on accepted arm
- iAbort  in  1  abandon the capture in progress
- oPxl  out  OUT_W  output pixel
- oDVAL  out  1  oPxl valid, single-cycle pulse
- oIdx  out  clog2(NX*NY)  raster index of oPxl, row*NX + col
- oDone  out  1  one-cycle pulse after the last pixel of a frame
- oBusy  out  1  high in WAIT_SOF or CAPTURE

Behaviour:
- Reset values: all outputs 0; state IDLE; accumulators 0; latched mode 0.
- FSM:
  - IDLE: iArm -> WAIT_SOF; latch iMode.
  - WAIT_SOF: iDVAL with iX==0 and iY==0 -> CAPTURE; that pixel is processed normally.
  - CAPTURE: emits pixels; after the emission with oIdx == NX*NY-1 -> DONE.
  - DONE: lasts one cycle with oDone=1, then -> IDLE.
  - iAbort in WAIT_SOF or CAPTURE -> IDLE next cycle. No oDone. Accumulators cleared.
  - iAbort has priority over a same-cycle emission; that emission is suppressed.
  - iArm outside IDLE is ignored, including a same-cycle iArm in DONE.
- Sample grid: column c (0..NX-1) is at X0+c*SX; row r (0..NY-1) is at Y0+r*SY. Pixels outside the grid are ignored.
- Stride selection uses phase counters or comparators. No run-time % or / operators.
- Mode 0 (point sample):
  - A pixel with iDVAL at exactly a grid point emits on the next cycle.
  - oPxl = iGray[IN_W-1 -: OUT_W]; oIdx = r*NX + c.
- Mode 1 (box average):
  - Block (r,c) covers columns X0+c*SX .. +2^AVG_LOG2-1 and rows Y0+r*SY .. +2^AVG_LOG2-1.
  - Keep NX column accumulators, each IN_W+2*AVG_LOG2 bits wide.
  - Each in-block pixel is added to accumulator c.
  - On the block's bottom-right pixel: sum = acc[c] + iGray; avg = sum >> (2*AVG_LOG2), truncating; oPxl = avg[IN_W-1 -: OUT_W].
  - Emission is 1 cycle after that pixel; acc[c] clears in the same cycle.
- Latency in both modes: exactly 1 cycle from the qualifying input pixel to oDVAL.
- oIdx and oPxl hold their last value when oDVAL=0. oIdx resets to 0 in IDLE.
- iDVAL low stalls nothing; coordinates alone qualify a pixel, gated by iDVAL.
- If the frame restarts (iX==0, iY==0) in CAPTURE before completion:
  - Restart the capture.
  - Clear accumulators.
  - The emission counter returns to 0.
- Reset mid-frame: immediate return to IDLE; the block must be re-armed.

Test Plan:
- Defaults, mode 0, arm, full 640x480 ramp frame (gray = {iX[5:0],iY[5:0]}) -> 784 oDVAL pulses. First pulse at (27,17), oPxl = gray[11:4], oIdx=0. Last pulse at (594,449), oIdx=783. oDone one cycle after the last pulse.
- Mode 1, AVG_LOG2=1, constant gray 0xAB0 with pixel (27,17) = 0xAB4 -> first oPxl = ((3*0xAB0+0xAB4)>>2)[11:4] = 0xAB. First emission 1 cycle after pixel (28,18). 784 outputs.
- Pixels (26,17), (27,16), (48,17) presented without arm -> no oDVAL. After arm, pixel (48,17) presented -> oIdx=1 emitted.
- iAbort asserted after 100 outputs -> oBusy low next cycle, no oDone. Re-arm plus a full frame -> 784 outputs starting at oIdx 0.
- iArm pulsed during CAPTURE and during DONE -> ignored; exactly one oDone. Latched mode unchanged when iMode toggles mid-frame.
- iRST low at output 400, then released; new frame without arm -> no outputs. Arm plus frame -> 784 outputs.
